// File: rtl/countdown_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : countdown_ctrl
// Brief    : mm:ss BCD countdown timer core (preset edit, run/pause, alarm blink)
// Revision : 1.0 - initial release
// ============================================================================
module countdown_ctrl #(
    parameter int TICK_DIV  = 1000,
    parameter int BLINK_DIV = 250
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        CE,
    input  logic        KEY_START,
    input  logic        KEY_UP,
    input  logic        KEY_DOWN,
    input  logic        KEY_RST,
    output logic [15:0] Q,
    output logic [3:0]  DIG_EN,
    output logic        RUNNING,
    output logic        ALARM
);

    localparam int PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PW-1:0] c_presc_max = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] c_blink_max = BW'(BLINK_DIV - 1);

    localparam logic [1:0] c_st_set   = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_pause = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    // +1 s with carries through the BCD digits; saturates at 99:59.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v == 16'h9959) return v;
        if (r[3:0] != 4'd9) begin r[3:0] = r[3:0] + 4'd1; return r; end
        r[3:0] = 4'd0;
        if (r[7:4] != 4'd5) begin r[7:4] = r[7:4] + 4'd1; return r; end
        r[7:4] = 4'd0;
        if (r[11:8] != 4'd9) begin r[11:8] = r[11:8] + 4'd1; return r; end
        r[11:8]  = 4'd0;
        r[15:12] = r[15:12] + 4'd1;
        return r;
    endfunction

    // -1 s with borrows through the BCD digits; saturates at 00:00.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v == 16'h0000) return v;
        if (r[3:0] != 4'd0) begin r[3:0] = r[3:0] - 4'd1; return r; end
        r[3:0] = 4'd9;
        if (r[7:4] != 4'd0) begin r[7:4] = r[7:4] - 4'd1; return r; end
        r[7:4] = 4'd5;
        if (r[11:8] != 4'd0) begin r[11:8] = r[11:8] - 4'd1; return r; end
        r[11:8]  = 4'd9;
        r[15:12] = r[15:12] - 4'd1;
        return r;
    endfunction

    logic [1:0]    r_state, w_state_nxt;
    logic [15:0]   r_q, w_q_nxt;
    logic [15:0]   r_preset, w_preset_nxt;
    logic [PW-1:0] r_presc, w_presc_nxt;
    logic [BW-1:0] r_blink, w_blink_nxt;
    logic [3:0]    r_dig_en, w_dig_en_nxt;
    logic          r_running, r_alarm;
    logic [15:0]   w_q_dec;
    logic          w_any_key;

    assign w_q_dec   = bcd_dec(r_q);
    assign w_any_key = KEY_START | KEY_UP | KEY_DOWN | KEY_RST;

    always_comb begin
        w_state_nxt  = r_state;
        w_q_nxt      = r_q;
        w_preset_nxt = r_preset;
        w_presc_nxt  = r_presc;
        w_blink_nxt  = r_blink;
        w_dig_en_nxt = 4'b1111;
        case (r_state)
            c_st_set: begin
                if (KEY_RST) begin
                    w_q_nxt      = 16'h0000;
                    w_preset_nxt = 16'h0000;
                end else if (KEY_START) begin
                    if (r_q != 16'h0000) begin
                        w_preset_nxt = r_q;
                        w_presc_nxt  = '0;
                        w_state_nxt  = c_st_run;
                    end
                end else if (KEY_UP) begin
                    w_q_nxt = bcd_inc(r_q);
                end else if (KEY_DOWN) begin
                    w_q_nxt = w_q_dec;
                end
            end
            c_st_run: begin
                if (KEY_RST) begin
                    w_q_nxt     = r_preset;
                    w_presc_nxt = '0;
                    w_state_nxt = c_st_set;
                end else begin
                    if (CE) begin
                        if (r_presc == c_presc_max) begin
                            w_presc_nxt = '0;
                            w_q_nxt     = w_q_dec;
                            if (w_q_dec == 16'h0000) begin
                                w_state_nxt = c_st_done;
                                w_blink_nxt = '0;
                            end
                        end else begin
                            w_presc_nxt = r_presc + PW'(1);
                        end
                    end
                    // Reaching zero wins over a simultaneous pause request.
                    if (KEY_START && (w_state_nxt != c_st_done))
                        w_state_nxt = c_st_pause;
                end
            end
            c_st_pause: begin
                if (KEY_RST) begin
                    w_q_nxt     = r_preset;
                    w_state_nxt = c_st_set;
                end else if (KEY_START) begin
                    w_state_nxt = c_st_run;
                end
            end
            default: begin
                w_dig_en_nxt = r_dig_en;
                if (w_any_key) begin
                    w_q_nxt      = r_preset;
                    w_state_nxt  = c_st_set;
                    w_blink_nxt  = '0;
                    w_dig_en_nxt = 4'b1111;
                end else if (CE) begin
                    if (r_blink == c_blink_max) begin
                        w_blink_nxt  = '0;
                        w_dig_en_nxt = ~r_dig_en;
                    end else begin
                        w_blink_nxt = r_blink + BW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state   <= c_st_set;
            r_q       <= 16'h0000;
            r_preset  <= 16'h0000;
            r_presc   <= '0;
            r_blink   <= '0;
            r_dig_en  <= 4'b1111;
            r_running <= 1'b0;
            r_alarm   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_q       <= w_q_nxt;
            r_preset  <= w_preset_nxt;
            r_presc   <= w_presc_nxt;
            r_blink   <= w_blink_nxt;
            r_dig_en  <= w_dig_en_nxt;
            r_running <= (w_state_nxt == c_st_run);
            r_alarm   <= (w_state_nxt == c_st_done);
        end
    end

    assign Q       = r_q;
    assign DIG_EN  = r_dig_en;
    assign RUNNING = r_running;
    assign ALARM   = r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_countdown_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_countdown_ctrl
// Brief    : directed self-checking bench for countdown_ctrl (TICK_DIV=4, BLINK_DIV=3)
// Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        k_start = 1'b0, k_up = 1'b0, k_down = 1'b0, k_rst = 1'b0;
    logic [15:0] q;
    logic [3:0]  dig_en;
    logic        running, alarm;

    int n_tests = 0;
    int n_fail  = 0;

    countdown_ctrl #(.TICK_DIV(4), .BLINK_DIV(3)) dut (
        .CLK       (clk),
        .CLR       (rst),
        .CE        (ce),
        .KEY_START (k_start),
        .KEY_UP    (k_up),
        .KEY_DOWN  (k_down),
        .KEY_RST   (k_rst),
        .Q         (q),
        .DIG_EN    (dig_en),
        .RUNNING   (running),
        .ALARM     (alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock with the given keys {rst,start,up,down} and CE; returns at posedge+1.
    task automatic step(input logic [3:0] keys, input logic c);
        {k_rst, k_start, k_up, k_down} = keys;
        ce = c;
        @(posedge clk);
        #1;
        {k_rst, k_start, k_up, k_down} = 4'b0000;
        ce = 1'b0;
    endtask

    task automatic press(input logic [3:0] keys, input int n);
        for (int i = 0; i < n; i++) step(keys, 1'b0);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 1'b1);
    endtask

    localparam logic [3:0] K_RST = 4'b1000, K_START = 4'b0100, K_UP = 4'b0010, K_DOWN = 4'b0001;

    initial begin
        #12;
        check("reset_q",       {16'h0, q},     32'h0000);
        check("reset_dig",     {28'h0, dig_en}, 32'hf);
        check("reset_running", {31'h0, running}, 32'h0);
        check("reset_alarm",   {31'h0, alarm},   32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Edit mode: saturation at both ends
        press(K_DOWN, 3);
        check("edit_down_sat", {16'h0, q}, 32'h0000);
        press(K_UP, 61);
        check("edit_up_61", {16'h0, q}, 32'h0101);
        press(K_UP, 5938);
        check("edit_reach_max", {16'h0, q}, 32'h9959);
        press(K_UP, 1);
        check("edit_up_sat", {16'h0, q}, 32'h9959);
        press(K_DOWN, 1);
        check("edit_down_from_max", {16'h0, q}, 32'h9958);
        press(K_RST, 1);
        check("edit_clear", {16'h0, q}, 32'h0000);

        // Borrow across minutes
        press(K_UP, 600);
        check("set_10_00", {16'h0, q}, 32'h1000);
        press(K_START, 1);
        check("run_running", {31'h0, running}, 32'h1);
        tick(3);
        check("run_before_tick", {16'h0, q}, 32'h1000);
        tick(1);
        check("run_borrow", {16'h0, q}, 32'h0959);
        tick(4);
        check("run_second_tick", {16'h0, q}, 32'h0958);
        press(K_UP | K_DOWN, 1);
        check("run_updown_ignored", {16'h0, q}, 32'h0958);
        press(K_RST, 1);
        check("run_reload", {16'h0, q}, 32'h1000);
        check("run_reload_state", {31'h0, running}, 32'h0);

        // Done and blink
        press(K_RST, 1);
        press(K_UP, 2);
        press(K_START, 1);
        tick(7);
        check("done_pre_q", {16'h0, q}, 32'h0001);
        check("done_pre_alarm", {31'h0, alarm}, 32'h0);
        tick(1);
        check("done_q", {16'h0, q}, 32'h0000);
        check("done_alarm", {31'h0, alarm}, 32'h1);
        check("done_running", {31'h0, running}, 32'h0);
        check("done_dig_entry", {28'h0, dig_en}, 32'hf);
        tick(2);
        check("blink_hold", {28'h0, dig_en}, 32'hf);
        tick(1);
        check("blink_off", {28'h0, dig_en}, 32'h0);
        tick(3);
        check("blink_on", {28'h0, dig_en}, 32'hf);
        tick(3);
        check("blink_off2", {28'h0, dig_en}, 32'h0);
        press(K_UP, 1);
        check("done_exit_q", {16'h0, q}, 32'h0002);
        check("done_exit_alarm", {31'h0, alarm}, 32'h0);
        check("done_exit_dig", {28'h0, dig_en}, 32'hf);

        // Pause holds time and prescaler
        press(K_RST, 1);
        press(K_UP, 5);
        press(K_START, 1);
        tick(6);
        check("pause_pre", {16'h0, q}, 32'h0004);
        press(K_START, 1);
        check("pause_running", {31'h0, running}, 32'h0);
        tick(20);
        check("pause_frozen", {16'h0, q}, 32'h0004);
        press(K_START, 1);
        check("resume_running", {31'h0, running}, 32'h1);
        tick(1);
        check("resume_presc_held", {16'h0, q}, 32'h0004);
        tick(1);
        check("resume_tick", {16'h0, q}, 32'h0003);

        // Key priority and start-at-zero
        press(K_RST | K_START, 1);
        check("prio_reload_q", {16'h0, q}, 32'h0005);
        check("prio_state", {31'h0, running}, 32'h0);
        press(K_RST, 1);
        press(K_START, 1);
        check("start_zero_ignored", {31'h0, running}, 32'h0);
        check("start_zero_q", {16'h0, q}, 32'h0000);

        // Final tick and pause together still reach DONE
        press(K_UP, 1);
        press(K_START, 1);
        tick(3);
        step(K_START, 1'b1);
        check("tick_start_alarm", {31'h0, alarm}, 32'h1);
        check("tick_start_q", {16'h0, q}, 32'h0000);
        press(K_DOWN, 1);
        check("done_down_exit", {16'h0, q}, 32'h0001);

        // Asynchronous clear mid-run
        press(K_UP, 2);
        press(K_START, 1);
        tick(2);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("async_q", {16'h0, q}, 32'h0000);
        check("async_running", {31'h0, running}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        press(K_RST | K_UP, 1);
        check("async_preset_lost", {16'h0, q}, 32'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
